// File: rtl/decoder_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_stage_pkg
//  Description : Shared RV32 opcode/funct constants, immediate-format enum,
//                decoded-control bundle and the opcode-to-format helper.
//  Revision    : 1.0  initial release
// ============================================================================
package decoder_stage_pkg;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] c_op_load     = 5'b00000;
    localparam logic [4:0] c_op_misc_mem = 5'b00011;
    localparam logic [4:0] c_op_op_imm   = 5'b00100;
    localparam logic [4:0] c_op_auipc    = 5'b00101;
    localparam logic [4:0] c_op_store    = 5'b01000;
    localparam logic [4:0] c_op_op       = 5'b01100;
    localparam logic [4:0] c_op_lui      = 5'b01101;
    localparam logic [4:0] c_op_branch   = 5'b11000;
    localparam logic [4:0] c_op_jalr     = 5'b11001;
    localparam logic [4:0] c_op_jal      = 5'b11011;
    localparam logic [4:0] c_op_system   = 5'b11100;

    // funct7 values accepted on OP
    localparam logic [6:0] c_funct7_base   = 7'b0000000;
    localparam logic [6:0] c_funct7_alt    = 7'b0100000;
    localparam logic [6:0] c_funct7_muldiv = 7'b0000001;

    // Branch funct3 encodings
    localparam logic [2:0] c_f3_beq   = 3'b000;
    localparam logic [2:0] c_f3_bne   = 3'b001;
    localparam logic [2:0] c_f3_rsv0  = 3'b010;
    localparam logic [2:0] c_f3_rsv1  = 3'b011;
    localparam logic [2:0] c_f3_blt   = 3'b100;
    localparam logic [2:0] c_f3_bge   = 3'b101;
    localparam logic [2:0] c_f3_bltu  = 3'b110;
    localparam logic [2:0] c_f3_bgeu  = 3'b111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_fmt_e;

    // Decoded fields except the XLEN-wide immediate (kept separately)
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] opcode;
        logic [5:0] branchmask;
        logic       illegal;
    } dec_ctrl_t;

    // Anything not explicitly S/B/U/J uses the I-type layout
    function automatic imm_fmt_e imm_fmt(input logic [4:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            c_op_store:          fmt = IMM_S;
            c_op_branch:         fmt = IMM_B;
            c_op_lui, c_op_auipc: fmt = IMM_U;
            c_op_jal:            fmt = IMM_J;
            default:             fmt = IMM_I;
        endcase
        return fmt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_stage_decode_fields.sv
`default_nettype none
// ============================================================================
//  Module      : decode_fields
//  Description : Combinational field extraction, immediate generation,
//                branch one-hot and illegal-instruction detection.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_fields
    import decoder_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]     i_instr,
    output dec_ctrl_t       o_ctrl,
    output logic [XLEN-1:0] o_imm
);

    logic [4:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_known_op;
    logic        w_bad_branch;
    logic        w_bad_op;
    logic        w_illegal;
    logic [5:0]  w_branchmask;
    logic [31:0] w_imm32;

    assign w_opcode = i_instr[6:2];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Only the base-ISA major opcodes this core executes are recognised
    always_comb begin
        w_known_op = 1'b0;
        case (w_opcode)
            c_op_load, c_op_store, c_op_branch, c_op_jal, c_op_jalr,
            c_op_op, c_op_op_imm, c_op_lui, c_op_auipc,
            c_op_misc_mem, c_op_system: w_known_op = 1'b1;
            default:                    w_known_op = 1'b0;
        endcase
    end

    // OP accepts base/alt funct7 always, MULDIV only with the M extension
    always_comb begin
        w_bad_op = 1'b0;
        if (w_opcode == c_op_op) begin
            case (w_funct7)
                c_funct7_base, c_funct7_alt: w_bad_op = 1'b0;
                c_funct7_muldiv:             w_bad_op = !ENABLE_M;
                default:                     w_bad_op = 1'b1;
            endcase
        end
    end

    assign w_bad_branch = (w_opcode == c_op_branch) &&
                          ((w_funct3 == c_f3_rsv0) || (w_funct3 == c_f3_rsv1));

    assign w_illegal = (i_instr[1:0] != 2'b11) || !w_known_op ||
                       w_bad_branch || w_bad_op;

    // One-hot branch condition; illegal words never raise a mask bit
    always_comb begin
        w_branchmask = 6'b000000;
        if (!w_illegal && (w_opcode == c_op_branch)) begin
            case (w_funct3)
                c_f3_beq:  w_branchmask = 6'b000001;
                c_f3_bne:  w_branchmask = 6'b000010;
                c_f3_blt:  w_branchmask = 6'b000100;
                c_f3_bge:  w_branchmask = 6'b001000;
                c_f3_bltu: w_branchmask = 6'b010000;
                c_f3_bgeu: w_branchmask = 6'b100000;
                default:   w_branchmask = 6'b000000;
            endcase
        end
    end

    // Build the 32-bit immediate; every format has its sign in instr[31]
    always_comb begin
        w_imm32 = 32'h0;
        case (imm_fmt(w_opcode))
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'h000};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        endcase
    end

    generate
        if (XLEN > 32) begin : g_imm_ext
            assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_native
            assign o_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

    assign o_ctrl = '{
        rd:         i_instr[11:7],
        funct3:     w_funct3,
        funct7:     w_funct7,
        opcode:     w_opcode,
        branchmask: w_branchmask,
        illegal:    w_illegal
    };

endmodule
`default_nettype wire

// File: rtl/decoder_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_stage
//  Description : Valid/ready instruction decode stage with a one-deep skid
//                entry behind the output register (two instructions total),
//                flush, PC pass-through and illegal-instruction flagging.
//  Revision    : 1.0  initial release
// ============================================================================
module decoder_stage
    import decoder_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter bit              ENABLE_M = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            I_clk,
    input  logic            I_reset_n,
    input  logic            I_valid,
    output logic            O_ready,
    input  logic [31:0]     I_instr,
    input  logic [XLEN-1:0] I_pc,
    input  logic            I_flush,
    output logic [4:0]      O_rs1,
    output logic [4:0]      O_rs2,
    output logic            O_valid,
    input  logic            I_ready,
    output logic [XLEN-1:0] O_pc,
    output logic [4:0]      O_rd,
    output logic [4:0]      O_opcode,
    output logic [2:0]      O_funct3,
    output logic [6:0]      O_funct7,
    output logic [XLEN-1:0] O_imm,
    output logic [5:0]      O_branchmask,
    output logic            O_illegal
);

    dec_ctrl_t       w_in_ctrl;
    logic [XLEN-1:0] w_in_imm;
    logic            w_accept;
    logic            w_out_free;

    logic            r_out_valid;
    dec_ctrl_t       r_out_ctrl;
    logic [XLEN-1:0] r_out_imm;
    logic [XLEN-1:0] r_out_pc;

    logic            r_skid_valid;
    dec_ctrl_t       r_skid_ctrl;
    logic [XLEN-1:0] r_skid_imm;
    logic [XLEN-1:0] r_skid_pc;

    logic            r_ready;

    // Register-file addresses bypass the stage so operand reads overlap decode
    assign O_rs1 = I_instr[19:15];
    assign O_rs2 = I_instr[24:20];

    decode_fields #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode_fields (
        .i_instr (I_instr),
        .o_ctrl  (w_in_ctrl),
        .o_imm   (w_in_imm)
    );

    // r_ready mirrors !r_skid_valid; accept only needs the registered copy
    assign w_accept   = I_valid && r_ready;
    assign w_out_free = !r_out_valid || I_ready;

    // Output register + skid entry; flush beats both accept and consume
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_ctrl   <= '0;
            r_out_imm    <= '0;
            r_out_pc     <= RESET_PC;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_imm   <= '0;
            r_skid_pc    <= '0;
            r_ready      <= 1'b1;
        end else if (I_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else if (w_out_free) begin
            // Output slot frees this cycle: the older skid entry goes first.
            // A held skid entry implies r_ready=0, so no accept competes.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_ctrl   <= r_skid_ctrl;
                r_out_imm    <= r_skid_imm;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= 1'b0;
                r_ready      <= 1'b1;
            end else if (w_accept) begin
                r_out_valid  <= 1'b1;
                r_out_ctrl   <= w_in_ctrl;
                r_out_imm    <= w_in_imm;
                r_out_pc     <= I_pc;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the newcomer and stop fetch next cycle
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= w_in_ctrl;
            r_skid_imm   <= w_in_imm;
            r_skid_pc    <= I_pc;
            r_ready      <= 1'b0;
        end
    end

    assign O_ready      = r_ready;
    assign O_valid      = r_out_valid;
    assign O_pc         = r_out_pc;
    assign O_rd         = r_out_ctrl.rd;
    assign O_opcode     = r_out_ctrl.opcode;
    assign O_funct3     = r_out_ctrl.funct3;
    assign O_funct7     = r_out_ctrl.funct7;
    assign O_imm        = r_out_imm;
    assign O_branchmask = r_out_ctrl.branchmask;
    assign O_illegal    = r_out_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decoder_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_stage
//  Description : Self-checking bench for decoder_stage; a 32-bit/M-enabled
//                and a 64-bit/M-disabled instance share one stimulus stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decoder_stage;

    localparam logic [31:0] c_rpc32 = 32'h0000_1000;
    localparam logic [63:0] c_rpc64 = 64'h8000_0000_0000_2000;

    logic        I_clk = 1'b0;
    logic        I_reset_n = 1'b0;
    logic        I_valid = 1'b0;
    logic [31:0] I_instr = 32'h0;
    logic [63:0] pc64 = 64'h0;
    logic        I_flush = 1'b0;
    logic        I_ready = 1'b0;

    logic        a_ready, a_valid, a_ill;
    logic [4:0]  a_rs1, a_rs2, a_rd, a_opc;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [31:0] a_pc, a_imm;
    logic [5:0]  a_bm;

    logic        b_ready, b_valid, b_ill;
    logic [4:0]  b_rs1, b_rs2, b_rd, b_opc;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [63:0] b_pc, b_imm;
    logic [5:0]  b_bm;

    int n_chk = 0;
    int n_err = 0;

    always #5 I_clk = ~I_clk;

    decoder_stage #(.XLEN(32), .ENABLE_M(1'b1), .RESET_PC(c_rpc32)) u_dut32 (
        .I_clk(I_clk), .I_reset_n(I_reset_n), .I_valid(I_valid), .O_ready(a_ready),
        .I_instr(I_instr), .I_pc(pc64[31:0]), .I_flush(I_flush),
        .O_rs1(a_rs1), .O_rs2(a_rs2), .O_valid(a_valid), .I_ready(I_ready),
        .O_pc(a_pc), .O_rd(a_rd), .O_opcode(a_opc), .O_funct3(a_f3),
        .O_funct7(a_f7), .O_imm(a_imm), .O_branchmask(a_bm), .O_illegal(a_ill)
    );

    decoder_stage #(.XLEN(64), .ENABLE_M(1'b0), .RESET_PC(c_rpc64)) u_dut64 (
        .I_clk(I_clk), .I_reset_n(I_reset_n), .I_valid(I_valid), .O_ready(b_ready),
        .I_instr(I_instr), .I_pc(pc64), .I_flush(I_flush),
        .O_rs1(b_rs1), .O_rs2(b_rs2), .O_valid(b_valid), .I_ready(I_ready),
        .O_pc(b_pc), .O_rd(b_rd), .O_opcode(b_opc), .O_funct3(b_f3),
        .O_funct7(b_f7), .O_imm(b_imm), .O_branchmask(b_bm), .O_illegal(b_ill)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference decode, straight from the ISA rules ----------
    typedef struct packed {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  opc;
        logic [63:0] imm;
        logic [5:0]  bm;
        logic        ill;
    } ref_t;

    function automatic ref_t ref_dec(input logic [31:0] w, input bit m_en);
        ref_t r;
        logic known;
        r.rd  = w[11:7];
        r.f3  = w[14:12];
        r.f7  = w[31:25];
        r.opc = w[6:2];
        case (r.opc)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: known = 1'b1;
            default: known = 1'b0;
        endcase
        r.ill = (w[1:0] != 2'b11) || !known ||
                (r.opc == 5'b11000 && (r.f3 == 3'd2 || r.f3 == 3'd3)) ||
                (r.opc == 5'b01100 && !(r.f7 == 7'd0 || r.f7 == 7'h20 || (m_en && r.f7 == 7'd1)));
        case (r.opc)
            5'b01000:           r.imm = {{52{w[31]}}, w[31:25], w[11:7]};
            5'b11000:           r.imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            5'b01101, 5'b00101: r.imm = {{32{w[31]}}, w[31:12], 12'h000};
            5'b11011:           r.imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:            r.imm = {{52{w[31]}}, w[31:20]};
        endcase
        r.bm = 6'd0;
        if (!r.ill && r.opc == 5'b11000) begin
            case (r.f3)
                3'd0: r.bm = 6'd1;
                3'd1: r.bm = 6'd2;
                3'd4: r.bm = 6'd4;
                3'd5: r.bm = 6'd8;
                3'd6: r.bm = 6'd16;
                3'd7: r.bm = 6'd32;
                default: r.bm = 6'd0;
            endcase
        end
        return r;
    endfunction

    // ---------------- stage model: a 2-deep in-order queue -------------------
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    item_t q[$];
    bit    m_ready = 1'b1;

    always @(posedge I_clk or negedge I_reset_n) begin
        bit acc;
        if (!I_reset_n || I_flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            acc = I_valid && m_ready;
            if (q.size() > 0 && I_ready) void'(q.pop_front());
            if (acc) q.push_back({I_instr, pc64});
            m_ready = (q.size() < 2);
        end
    end

    // ---------------- per-cycle comparison ------------------------------------
    always @(negedge I_clk) begin
        ref_t r32, r64;
        bit   ev;
        ev = (q.size() > 0);
        chk("valid32", 64'(a_valid), 64'(ev));
        chk("valid64", 64'(b_valid), 64'(ev));
        chk("ready32", 64'(a_ready), 64'(m_ready));
        chk("ready64", 64'(b_ready), 64'(m_ready));
        chk("rs1_32", 64'(a_rs1), 64'(I_instr[19:15]));
        chk("rs2_64", 64'(b_rs2), 64'(I_instr[24:20]));
        if (ev) begin
            r32 = ref_dec(q[0].instr, 1'b1);
            r64 = ref_dec(q[0].instr, 1'b0);
            chk("pc32",   64'(a_pc),  64'(q[0].pc[31:0]));
            chk("pc64",   b_pc,       q[0].pc);
            chk("rd32",   64'(a_rd),  64'(r32.rd));
            chk("opc32",  64'(a_opc), 64'(r32.opc));
            chk("f3_32",  64'(a_f3),  64'(r32.f3));
            chk("f7_32",  64'(a_f7),  64'(r32.f7));
            chk("imm32",  64'(a_imm), 64'(r32.imm[31:0]));
            chk("bm32",   64'(a_bm),  64'(r32.bm));
            chk("ill32",  64'(a_ill), 64'(r32.ill));
            chk("rd64",   64'(b_rd),  64'(r64.rd));
            chk("opc64",  64'(b_opc), 64'(r64.opc));
            chk("f3_64",  64'(b_f3),  64'(r64.f3));
            chk("f7_64",  64'(b_f7),  64'(r64.f7));
            chk("imm64",  b_imm,      r64.imm);
            chk("bm64",   64'(b_bm),  64'(r64.bm));
            chk("ill64",  64'(b_ill), 64'(r64.ill));
        end
    end

    // ---------------- stimulus -------------------------------------------------
    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 8) begin
            w[1:0] = 2'b11;
            case ($urandom_range(0, 10))
                0: w[6:2] = 5'b00000;
                1: w[6:2] = 5'b00011;
                2: w[6:2] = 5'b00100;
                3: w[6:2] = 5'b00101;
                4: w[6:2] = 5'b01000;
                5: w[6:2] = 5'b01100;
                6: w[6:2] = 5'b01101;
                7: w[6:2] = 5'b11000;
                8: w[6:2] = 5'b11001;
                9: w[6:2] = 5'b11011;
                default: w[6:2] = 5'b11100;
            endcase
            if (w[6:2] == 5'b01100) begin
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
        end
        return w;
    endfunction

    localparam logic [31:0] c_a = 32'h0010_0093; // addi x1,x0,1
    localparam logic [31:0] c_b = 32'h0020_0113; // addi x2,x0,2
    localparam logic [31:0] c_c = 32'h0030_0193; // addi x3,x0,3

    initial begin
        // reset state
        I_reset_n = 1'b0;
        repeat (2) tick();
        chk("rst_valid",  64'(a_valid), 64'd0);
        chk("rst_ready",  64'(a_ready), 64'd1);
        chk("rst_pc32",   64'(a_pc),    64'(c_rpc32));
        chk("rst_pc64",   b_pc,         c_rpc64);
        chk("rst_imm64",  b_imm,        64'd0);
        chk("rst_rd",     64'(a_rd),    64'd0);
        chk("rst_ill",    64'(a_ill),   64'd0);
        chk("rst_bm",     64'(a_bm),    64'd0);
        I_reset_n = 1'b1;
        tick();

        // pin the reference decoder against hand-decoded words
        chk("model_addi_imm", ref_dec(32'hFFF1_0093, 1'b1).imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_beq_bm",   64'(ref_dec(32'hFE00_0EE3, 1'b1).bm), 64'd1);
        chk("model_mul_noM",  64'(ref_dec(32'h0220_8033, 1'b0).ill), 64'd1);

        // addi x1,x2,-1
        I_ready = 1'b1; I_valid = 1'b1; I_instr = 32'hFFF1_0093; pc64 = 64'h100;
        #1;
        chk("addi_rs1_comb", 64'(a_rs1), 64'd2);
        tick();
        chk("addi_valid", 64'(a_valid), 64'd1);
        chk("addi_rd",    64'(a_rd),    64'd1);
        chk("addi_f3",    64'(a_f3),    64'd0);
        chk("addi_imm",   64'(a_imm),   64'hFFFF_FFFF);
        chk("addi_ill",   64'(a_ill),   64'd0);
        // beq x0,x0,-4
        I_instr = 32'hFE00_0EE3; pc64 = 64'h104;
        tick();
        chk("beq_bm",  64'(a_bm),  64'b000001);
        chk("beq_imm", 64'(a_imm), 64'hFFFF_FFFC);
        // all-zero word
        I_instr = 32'h0000_0000; pc64 = 64'h108;
        tick();
        chk("zero_ill", 64'(a_ill), 64'd1);
        chk("zero_bm",  64'(a_bm),  64'd0);
        // lui x1,0x80000 on 64-bit
        I_instr = 32'h8000_00B7; pc64 = 64'h10C;
        tick();
        chk("lui_imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
        // mul: legal with M, illegal without
        I_instr = 32'h0220_8033; pc64 = 64'h110;
        tick();
        chk("mul_ill64", 64'(b_ill), 64'd1);
        chk("mul_ill32", 64'(a_ill), 64'd0);
        I_valid = 1'b0;
        tick();

        // stall: A held, B in skid, C waits
        I_ready = 1'b0; I_valid = 1'b1; I_instr = c_a;
        tick();
        I_instr = c_b;
        tick();
        chk("skid_ready0", 64'(a_ready), 64'd0);
        I_instr = c_c;
        tick();
        chk("stall_hold_rd", 64'(a_rd), 64'd1);
        I_ready = 1'b1;
        tick();
        chk("drain_b", 64'(a_rd), 64'd2);
        tick();
        chk("drain_c", 64'(a_rd), 64'd3);
        I_valid = 1'b0;
        tick();
        chk("drained", 64'(a_valid), 64'd0);

        // flush with skid full and a same-cycle offer
        I_ready = 1'b0; I_valid = 1'b1; I_instr = c_a;
        tick();
        I_instr = c_b;
        tick();
        I_flush = 1'b1; I_instr = c_c;
        tick();
        chk("flush_valid", 64'(a_valid), 64'd0);
        chk("flush_ready", 64'(a_ready), 64'd1);
        I_flush = 1'b0; I_valid = 1'b0; I_ready = 1'b1;
        tick();
        chk("flush_nothing", 64'(a_valid), 64'd0);

        // asynchronous reset with skid full
        I_ready = 1'b0; I_valid = 1'b1; I_instr = c_a;
        tick();
        I_instr = c_b;
        tick();
        I_valid = 1'b0;
        @(negedge I_clk);
        #2;
        I_reset_n = 1'b0;
        #1;
        chk("arst_valid32", 64'(a_valid), 64'd0);
        chk("arst_ready32", 64'(a_ready), 64'd1);
        chk("arst_valid64", 64'(b_valid), 64'd0);
        tick();
        I_reset_n = 1'b1;
        I_valid = 1'b1; I_instr = c_c; I_ready = 1'b1;
        tick();
        chk("post_rst_lat", 64'(a_valid), 64'd1);
        chk("post_rst_rd",  64'(a_rd),    64'd3);
        I_valid = 1'b0;
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            I_valid = ($urandom_range(0, 9) < 7);
            I_instr = rand_instr();
            pc64    = {$urandom, $urandom};
            I_ready = ($urandom_range(0, 9) < 6);
            I_flush = ($urandom_range(0, 99) < 3);
            tick();
        end
        I_valid = 1'b0; I_flush = 1'b0; I_ready = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_stage.md
Name: decoder_stage

Overview:
Next-generation instruction decode stage. It replaces the single-register, enable-driven decoder with a valid/ready pipelined stage. The stage is parametrised in datapath width (XLEN) and extension support, and adds a 2-entry skid buffer, flush, PC pass-through and illegal-instruction detection. It sits between fetch and execute. Register-file read addresses stay combinational from the input so operand reads overlap decode.

Parameters:
XLEN, 32, datapath width; width of O_imm and O_pc; legal values 32 or 64.
ENABLE_M, 1, 1 = OP with funct7=7'b0000001 is legal (M extension); 0 = illegal.
RESET_PC, 0, value driven on O_pc while the stage is empty after reset.

Ports:
I_clk  in  1  clock, all state on rising edge
I_reset_n  in  1  asynchronous active-low reset
I_valid  in  1  fetch presents an instruction
O_ready  out  1  stage can accept this cycle
I_instr  in  32  instruction word
I_pc  in  XLEN  PC of I_instr
I_flush  in  1  discard all held and incoming instructions
O_rs1  out  5  I_instr[19:15], combinational
O_rs2  out  5  I_instr[24:20], combinational
O_valid  out  1  decoded instruction available
I_ready  in  1  execute accepts this cycle
O_pc  out  XLEN  PC of the output instruction
O_rd  out  5  destination register
O_opcode  out  5  instr[6:2]
O_funct3  out  3  instr[14:12]
O_funct7  out  7  instr[31:25]
O_imm  out  XLEN  sign-extended immediate
O_branchmask  out  6  one-hot {BGEU,BLTU,BGE,BLT,BNE,BEQ}
O_illegal  out  1  output instruction is illegal

Behaviour:
- Reset (async assert, sync release): O_valid=0, skid empty, O_ready=1. O_pc=RESET_PC. All other registered outputs are 0.
- Accept happens when I_valid && O_ready. Decode is combinational from I_instr; the result is registered. Latency is 1 cycle from accept to O_valid.
- Output register empty, or being consumed (I_ready=1): an accepted instruction loads the output register.
- Output valid and I_ready=0: an accepted instruction loads the skid entry. O_ready is registered as !skid_valid, so it drops the next cycle.
- Skid full and output consumed: the skid moves to the output and O_ready returns to 1 the next cycle.
- Order is always preserved and no instruction is duplicated or lost.
- O_valid must stay stable and outputs must hold while I_ready=0.
- Flush: the output register and skid are invalidated at the next edge, and any same-cycle accept is dropped. Flush wins over accept and consume. O_ready=1 the cycle after.
- Immediate select:
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI/AUIPC, {instr[31:12],12'b0}, sign-extended to XLEN from bit 31.
  - J-type: JAL, bit0=0.
  - I-type: all other opcodes.
  - Every form is sign-extended to XLEN.
- Illegal when any of:
  - instr[1:0]!=2'b11;
  - opcode outside {LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC, MISC_MEM, SYSTEM};
  - BRANCH with funct3 of 010 or 011;
  - OP with funct7 other than 0, 0100000, or 0000001 (the last only when ENABLE_M=1).
- Illegal instructions still flow through the stage with O_illegal=1 and O_branchmask=0 so execute can trap.
- O_branchmask: exactly one bit set for a legal BRANCH; 0 for everything else.
- Reset mid-operation: all state is cleared immediately, and in-flight instructions are discarded.

Decomposition:
- Opcode and funct constants come from the shared cpu/riscvdefs.vh header. Add OP_MISC_MEM, OP_SYSTEM and FUNCT7_MULDIV there if they are missing.
- One sub-module, decode_fields: purely combinational, parametrised by XLEN and ENABLE_M. It maps instr to {rd, funct3, funct7, opcode, imm, branchmask, illegal}.
- decode_fields is instantiated once on the incoming path, and the bundle is stored in the output and skid registers.

Test Plan:
- Reset then accept 0xFFF10093 (addi x1,x2,-1) with I_ready=1 -> next cycle O_valid=1, O_rd=1, O_funct3=0, O_imm=0xFFFFFFFF, O_illegal=0. O_rs1=2 in the same cycle as I_valid.
- Accept 0xFE000EE3 (beq x0,x0,-4) -> O_branchmask=6'b000001, O_imm=0xFFFFFFFC. Then 0x00000000 -> O_illegal=1, O_branchmask=0.
- I_ready=0, then three back-to-back valid instructions A, B, C -> A held on output, B in skid, O_ready=0 and C stalls. Raise I_ready -> outputs A, B, C on consecutive cycles.
- Skid full, then assert I_flush with I_valid=1 -> O_valid=0 next cycle, O_ready=1, and no flushed instruction ever appears.
- XLEN=64: accept 0x800000B7 (lui x1,0x80000) -> O_imm=0xFFFFFFFF80000000. With ENABLE_M=0, accept 0x02208033 (mul) -> O_illegal=1.
- Pull I_reset_n low asynchronously while the skid is full -> O_valid=0 and O_ready=1 without waiting for a clock edge. After release, the next accept yields latency 1.
